oric_tap_recorder: RTL and testbench

- Tape recorder: the capture-side counterpart of the Oric TAP player.
- Decodes the Oric cassette output waveform (K7_TAPEOUT, fast 2400/1200 Hz format) into framed bytes.
- Hands each byte to the SDRAM port2 arbiter with a toggle req/ack handshake, with a sequentially incremented byte address, so a recorded image can be saved as a .TAP file.

---
 rtl/oric_tap_recorder.sv | 233 +++++++++++++++++++++++
 tb/tb_oric_tap_recorder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oric_tap_recorder.sv
// Oric cassette capture: decodes the K7_TAPEOUT fast-format waveform
// (2400/1200 Hz) into framed bytes and hands each byte to the SDRAM port2
// writer over a toggle req/ack handshake with a sequential byte address.
//
// Ports:
//   clk        system clock (clk_24 domain)
//   reset      asynchronous active-high reset
//   ce         1 MHz tick enable, one clk wide
//   enable     record armed; rising edge restarts the image at address 0
//   tape_in    raw tape output from the VIA (asynchronous)
//   byte_out   decoded byte, valid while byte_req != byte_ack
//   byte_addr  address of byte_out
//   byte_req   toggles once per new byte
//   byte_ack   toggled by the writer once the byte is stored
//   byte_count bytes stored since enable rose (next address)
//   recording  high whenever the decoder is not idle
//   parity_err sticky odd-parity failure
//   frame_err  sticky framing failure (bad stop bit or timeout mid-byte)
//   overrun    sticky: a byte completed while the writer was still busy
module oric_tap_recorder #(
   parameter int unsigned T_MIN     = 200,
   parameter int unsigned T_SPLIT   = 625,
   parameter int unsigned T_MAX     = 1200,
   parameter int unsigned SYNC_ONES = 16,
   parameter int unsigned STOP_BITS = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        enable,
   input  logic        tape_in,
   output logic [7:0]  byte_out,
   output logic [23:0] byte_addr,
   output logic        byte_req,
   input  logic        byte_ack,
   output logic [23:0] byte_count,
   output logic        recording,
   output logic        parity_err,
   output logic        frame_err,
   output logic        overrun
);

   localparam int unsigned CW = $clog2(T_MAX + 1);
   localparam int unsigned OW = $clog2(SYNC_ONES + 1);
   localparam int unsigned SW = $clog2(STOP_BITS + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_START_WAIT,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    sync_q;
   logic          enable_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [OW-1:0] ones_q, ones_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [SW-1:0] stop_q, stop_d;
   logic [7:0]    shift_q, shift_d;

   logic [7:0]    byte_out_d;
   logic [23:0]   byte_addr_d;
   logic          byte_req_d;
   logic [23:0]   byte_count_d;
   logic          recording_d;
   logic          parity_err_d;
   logic          frame_err_d;
   logic          overrun_d;

   logic          tape_rise;
   logic          edge_ok;
   logic          bit_val;
   logic          timeout;
   logic          enable_rise;

   // Two-flop synchronizer plus one more flop for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q   <= 3'b000;
         enable_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[1:0], tape_in};
         enable_q <= enable;
      end
   end

   assign tape_rise   = sync_q[1] & ~sync_q[2];
   assign edge_ok     = tape_rise && (cnt_q >= CW'(T_MIN));
   assign bit_val     = (cnt_q < CW'(T_SPLIT));
   assign timeout     = (cnt_q == CW'(T_MAX));
   assign enable_rise = enable & ~enable_q;

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ones_q     <= '0;
         bit_idx_q  <= '0;
         stop_q     <= '0;
         shift_q    <= '0;
         byte_out   <= '0;
         byte_addr  <= '0;
         byte_req   <= 1'b0;
         byte_count <= '0;
         recording  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ones_q     <= ones_d;
         bit_idx_q  <= bit_idx_d;
         stop_q     <= stop_d;
         shift_q    <= shift_d;
         byte_out   <= byte_out_d;
         byte_addr  <= byte_addr_d;
         byte_req   <= byte_req_d;
         byte_count <= byte_count_d;
         recording  <= recording_d;
         parity_err <= parity_err_d;
         frame_err  <= frame_err_d;
         overrun    <= overrun_d;
      end
   end

   // Next-state, period counter and byte framing.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ones_d       = ones_q;
      bit_idx_d    = bit_idx_q;
      stop_d       = stop_q;
      shift_d      = shift_q;
      byte_out_d   = byte_out;
      byte_addr_d  = byte_addr;
      byte_req_d   = byte_req;
      byte_count_d = byte_count;
      parity_err_d = parity_err;
      frame_err_d  = frame_err;
      overrun_d    = overrun;

      // Period counter: counts ce ticks since the last accepted edge.
      if (ce && !timeout)
         cnt_d = cnt_q + CW'(1);
      if (edge_ok)
         cnt_d = '0;

      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (enable_rise) begin
         state_d      = ST_SYNC;
         ones_d       = '0;
         cnt_d        = '0;
         byte_count_d = '0;
         parity_err_d = 1'b0;
         frame_err_d  = 1'b0;
         overrun_d    = 1'b0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_IDLE;
      end else if (timeout) begin
         // Line idle: a byte in flight is lost; between bytes it is harmless.
         if (state_q == ST_DATA || state_q == ST_PARITY)
            frame_err_d = 1'b1;
         state_d = ST_SYNC;
         ones_d  = '0;
      end else if (edge_ok) begin
         case (state_q)
            ST_SYNC: begin
               if (bit_val) begin
                  if (ones_q == OW'(SYNC_ONES - 1)) begin
                     state_d = ST_START_WAIT;
                     ones_d  = '0;
                  end else begin
                     ones_d = ones_q + OW'(1);
                  end
               end else begin
                  ones_d = '0;
               end
            end
            ST_START_WAIT: begin
               if (!bit_val) begin
                  state_d   = ST_DATA;
                  bit_idx_d = '0;
               end
            end
            ST_DATA: begin
               shift_d   = {bit_val, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7)
                  state_d = ST_PARITY;
            end
            ST_PARITY: begin
               // Odd parity: data plus parity bit must hold an odd number of ones.
               if (^{shift_q, bit_val} == 1'b0)
                  parity_err_d = 1'b1;
               state_d = ST_STOP;
               stop_d  = '0;
            end
            ST_STOP: begin
               if (!bit_val) begin
                  frame_err_d = 1'b1;
                  state_d     = ST_SYNC;
                  ones_d      = '0;
               end else if (stop_q == SW'(STOP_BITS - 1)) begin
                  // Handshake is free when req == ack, including an ack landing this clk.
                  if (byte_req == byte_ack) begin
                     byte_out_d   = shift_q;
                     byte_addr_d  = byte_count;
                     byte_req_d   = ~byte_req;
                     byte_count_d = byte_count + 24'd1;
                  end else begin
                     overrun_d = 1'b1;
                  end
                  state_d = ST_START_WAIT;
               end else begin
                  stop_d = stop_q + SW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      recording_d = (state_d != ST_IDLE);
   end

endmodule

// File: tb/tb_oric_tap_recorder.sv
// Directed bench for oric_tap_recorder. Timing is scaled down by 8 (parameters
// and bit periods alike) and ce fires every second clk.
module tb_oric_tap_recorder;

   localparam int unsigned T_MIN   = 25;
   localparam int unsigned T_SPLIT = 78;
   localparam int unsigned T_MAX   = 150;
   localparam int unsigned P1      = 50;   // 400 us one-bit period
   localparam int unsigned P0      = 100;  // 800 us zero-bit period
   localparam int unsigned CPT     = 2;    // clk per ce tick

   typedef struct packed {
      logic [7:0]  d;
      logic [23:0] a;
   } exp_t;

   logic        clk = 1'b0;
   logic        ce = 1'b0;
   logic        reset, enable, tape_in, byte_ack;
   logic [7:0]  byte_out;
   logic [23:0] byte_addr, byte_count;
   logic        byte_req, recording, parity_err, frame_err, overrun;

   int          compared = 0;
   int          mismatched = 0;
   exp_t        sb[$];
   logic [23:0] exp_count = '0;
   logic        req_seen = 1'b0;

   oric_tap_recorder #(
      .T_MIN(T_MIN), .T_SPLIT(T_SPLIT), .T_MAX(T_MAX),
      .SYNC_ONES(16), .STOP_BITS(3)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce), .enable(enable), .tape_in(tape_in),
      .byte_out(byte_out), .byte_addr(byte_addr), .byte_req(byte_req),
      .byte_ack(byte_ack), .byte_count(byte_count), .recording(recording),
      .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ce <= ~ce;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int unsigned n);
      repeat (n * CPT) @(negedge clk);
   endtask

   // One period minus its closing rising edge; optional short dip right after the opening edge.
   task automatic send_body(input int unsigned n, input bit gl);
      if (gl) begin
         wait_ticks(3);
         tape_in = 1'b0;
         wait_ticks(6);
         tape_in = 1'b1;
         wait_ticks(n / 2 - 9);
      end else begin
         wait_ticks(n / 2);
      end
      tape_in = 1'b0;
      wait_ticks(n - n / 2);
   endtask

   task automatic send_bit(input logic b, input bit gl);
      send_body(b ? P1 : P0, gl);
      tape_in = 1'b1;
   endtask

   task automatic send_sync();
      for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input bit push,
                             input bit bad2, input bit gl);
      if (push) begin
         sb.push_back('{d: d, a: exp_count});
         exp_count = exp_count + 24'd1;
      end
      send_bit(1'b0, gl);
      for (int i = 0; i < 8; i++) send_bit(d[i], gl);
      send_bit(p, gl);
      send_bit(1'b1, gl);
      if (bad2) begin
         send_bit(1'b0, 1'b0);
      end else begin
         send_bit(1'b1, gl);
         send_body(P1, gl);
         chk("req_before_last_stop", 32'(byte_req), 32'(req_seen));
         tape_in = 1'b1;
      end
   endtask

   task automatic finish_frame(input bit emit, input bit do_ack);
      exp_t e;
      repeat (6) @(negedge clk);
      if (emit) req_seen = ~req_seen;
      chk("byte_req", 32'(byte_req), 32'(req_seen));
      if (emit) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("byte_out", 32'(byte_out), 32'(e.d));
            chk("byte_addr", 32'(byte_addr), 32'(e.a));
         end
         if (do_ack) begin
            repeat (3) @(negedge clk);
            byte_ack = ~byte_ack;
         end
      end
   endtask

   task automatic rearm();
      enable = 1'b0;
      repeat (4) @(negedge clk);
      enable = 1'b1;
      exp_count = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic lead_in();
      tape_in = 1'b0;
      wait_ticks(10);
      tape_in = 1'b1;
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

   initial begin
      reset = 1'b1; enable = 1'b0; tape_in = 1'b0; byte_ack = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_byte_out", 32'(byte_out), 32'h0);
      chk("rst_byte_req", 32'(byte_req), 32'h0);
      chk("rst_byte_count", 32'(byte_count), 32'h0);
      chk("rst_recording", 32'(recording), 32'h0);
      chk("rst_flags", 32'({parity_err, frame_err, overrun}), 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Sync and decode 0xA5
      rearm();
      chk("rec_after_enable", 32'(recording), 32'h1);
      lead_in();
      send_sync();
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
      finish_frame(1'b1, 1'b1);
      chk("a5_count", 32'(byte_count), 32'h1);
      chk("a5_flags", 32'({parity_err, frame_err, overrun}), 32'h0);

      // Back-to-back bytes
      rearm();
      lead_in();
      send_sync();
      send_frame(8'h16, odd_par(8'h16), 1'b1, 1'b0, 1'b0);
      finish_frame(1'b1, 1'b1);
      send_frame(8'h16, odd_par(8'h16), 1'b1, 1'b0, 1'b0);
      finish_frame(1'b1, 1'b1);
      send_frame(8'h24, odd_par(8'h24), 1'b1, 1'b0, 1'b0);
      finish_frame(1'b1, 1'b1);
      chk("b2b_count", 32'(byte_count), 32'h3);

      // Parity error: byte still stored
      send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      finish_frame(1'b1, 1'b1);
      chk("par_err", 32'(parity_err), 32'h1);
      chk("par_frame_err", 32'(frame_err), 32'h0);
      chk("par_count", 32'(byte_count), 32'h4);

      // Framing error, then resync required
      rearm();
      chk("flags_cleared", 32'({parity_err, frame_err, overrun}), 32'h0);
      lead_in();
      send_sync();
      send_frame(8'h42, odd_par(8'h42), 1'b0, 1'b1, 1'b0);
      finish_frame(1'b0, 1'b0);
      chk("frame_err", 32'(frame_err), 32'h1);
      send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      finish_frame(1'b0, 1'b0);
      chk("nosync_count", 32'(byte_count), 32'h0);
      send_sync();
      send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0, 1'b0);
      finish_frame(1'b1, 1'b1);
      chk("resync_count", 32'(byte_count), 32'h1);
      chk("frame_err_sticky", 32'(frame_err), 32'h1);

      // Overrun: writer holds ack
      rearm();
      lead_in();
      send_sync();
      send_frame(8'h3C, odd_par(8'h3C), 1'b1, 1'b0, 1'b0);
      finish_frame(1'b1, 1'b0);
      send_frame(8'hC3, odd_par(8'hC3), 1'b0, 1'b0, 1'b0);
      finish_frame(1'b0, 1'b0);
      chk("overrun", 32'(overrun), 32'h1);
      chk("ovr_count", 32'(byte_count), 32'h1);
      chk("ovr_byte_out_stable", 32'(byte_out), 32'h3C);
      chk("ovr_addr_stable", 32'(byte_addr), 32'h0);
      byte_ack = ~byte_ack;

      // Glitch dips inside every bit are ignored
      send_frame(8'h99, odd_par(8'h99), 1'b1, 1'b0, 1'b1);
      finish_frame(1'b1, 1'b1);
      chk("glitch_count", 32'(byte_count), 32'h2);

      // Timeout mid-DATA
      rearm();
      chk("timeout_pre_fe", 32'(frame_err), 32'h0);
      lead_in();
      send_sync();
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      wait_ticks(25);
      tape_in = 1'b0;
      wait_ticks(188);
      chk("timeout_frame_err", 32'(frame_err), 32'h1);
      chk("timeout_recording", 32'(recording), 32'h1);
      chk("timeout_req", 32'(byte_req), 32'(req_seen));
      chk("timeout_count", 32'(byte_count), 32'h0);

      // enable low
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("disabled_recording", 32'(recording), 32'h0);
      chk("disabled_byte_out_held", 32'(byte_out), 32'h99);

      // Reset mid-DATA
      rearm();
      lead_in();
      send_sync();
      send_frame(8'h77, odd_par(8'h77), 1'b1, 1'b0, 1'b0);
      finish_frame(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      reset = 1'b1;
      byte_ack = 1'b0;
      req_seen = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_byte_out", 32'(byte_out), 32'h0);
      chk("mid_rst_byte_addr", 32'(byte_addr), 32'h0);
      chk("mid_rst_byte_req", 32'(byte_req), 32'h0);
      chk("mid_rst_byte_count", 32'(byte_count), 32'h0);
      chk("mid_rst_recording", 32'(recording), 32'h0);
      chk("mid_rst_flags", 32'({parity_err, frame_err, overrun}), 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
